// File: rtl/uart_tx_fifo.sv
// Byte FIFO that drains into the 8N1 UART transmitter one launch at a time, paced by tx_complete.
// Optional sticky overflow flag (ovf/ovf_clr) is built only when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sourceClk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  tx_cs,
    output logic                  tx_en,
    output logic [7:0]            tx_byte,
    input  logic                  tx_complete
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                  ovf,
    input  logic                  ovf_clr
`endif
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    state_t                state;
    logic                  push;
    logic                  pop;

    // Status flags come straight off the registered occupancy, so they never see a same-cycle bypass.
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = (state == S_IDLE) && (count != '0);

    // NOTE: the storage array has no reset; flushing only clears pointers and count, which is enough.
    always_ff @(posedge sourceClk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Launch sequencer: one-cycle active-low request, then hold busy until the transmitter reports done.
    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            tx_en   <= 1'b1;
            tx_cs   <= 1'b0;
            tx_byte <= 8'h00;
            busy    <= 1'b0;
        end else begin
            tx_cs <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state   <= S_LAUNCH;
                        tx_en   <= 1'b0;
                        busy    <= 1'b1;
                        tx_byte <= mem[rd_ptr];
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                    tx_en <= 1'b1;
                end
                S_WAIT: begin
                    if (tx_complete) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_en <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model plus a simple transmitter stand-in.
// Overflow checks are compiled in only when UART_TX_FIFO_OVF_EN is defined.
module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          sourceClk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx_complete = 1'b0;
    logic          full, empty, busy, tx_cs, tx_en;
    logic [DL:0]   count;
    logic [7:0]    tx_byte;
`ifdef UART_TX_FIFO_OVF_EN
    logic          ovf;
    logic          ovf_clr = 1'b0;
`endif

    always #5 sourceClk = ~sourceClk;

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .sourceClk   (sourceClk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .busy        (busy),
        .tx_cs       (tx_cs),
        .tx_en       (tx_en),
        .tx_byte     (tx_byte),
        .tx_complete (tx_complete)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: bytes accepted but not yet launched, plus launch/complete bookkeeping in edge numbers.
    logic [7:0] q[$];
    logic [7:0] launch_log[$];
    bit         outstanding = 1'b0;
    int         launch_edge = -10;
    int         last_done_edge = -1;
    int         edge_n = 0;
    logic [7:0] last_byte = 8'h00;
    bit         cs_exp = 1'b0;
    bit         ovf_m = 1'b0;
    bit         ovf_clr_d = 1'b0;
    bit         gap_chk = 1'b0;
    int         tx_delay = -1;
    int         cd = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tx_en",   32'(tx_en),   32'(!(outstanding && launch_edge == edge_n)));
        chk("busy",    32'(busy),    32'(outstanding));
        chk("tx_cs",   32'(tx_cs),   32'(cs_exp));
        chk("tx_byte", 32'(tx_byte), 32'(last_byte));
        chk("count",   32'(count),   32'(q.size()));
        chk("full",    32'(full),    32'(q.size() == DEPTH));
        chk("empty",   32'(empty),   32'(q.size() == 0));
`ifdef UART_TX_FIFO_OVF_EN
        chk("ovf",     32'(ovf),     32'(ovf_m));
`endif
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare 1 ns after the edge.
    task automatic cycle(input bit wr, input logic [7:0] d, input bit cmpl);
        bit fire, push_ok, pop_m, done;
        int e;
        fire = cmpl;
        if (cd == 0) begin
            fire = 1'b1;
            cd = -1;
        end else if (cd > 0) begin
            cd--;
        end
        wr_en = wr;
        wr_data = d;
        tx_complete = fire;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = ovf_clr_d;
`endif
        e = edge_n + 1;
        push_ok = wr && (q.size() < DEPTH);
        pop_m = !outstanding && (q.size() > 0);
        done = outstanding && fire && (e >= launch_edge + 2);
        if (wr && !push_ok) ovf_m = 1'b1;
        else if (ovf_clr_d) ovf_m = 1'b0;
        if (pop_m) begin
            last_byte = q.pop_front();
            outstanding = 1'b1;
            launch_edge = e;
        end
        if (done) begin
            outstanding = 1'b0;
            last_done_edge = e;
        end
        if (push_ok) q.push_back(d);
        cs_exp = 1'b1;
        @(posedge sourceClk);
        #1;
        edge_n = e;
        check_all();
        if (tx_en === 1'b0) begin
            launch_log.push_back(tx_byte);
            if (gap_chk && last_done_edge >= 0)
                chk("launch_gap", 32'(edge_n - last_done_edge), 32'd1);
            if (tx_delay >= 0) cd = tx_delay;
        end
        wr_en = 1'b0;
        tx_complete = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Power-on reset values.
        #12;
        check_all();
        chk("rst_tx_en", 32'(tx_en), 32'd1);
        chk("rst_tx_cs", 32'(tx_cs), 32'd0);
        @(negedge sourceClk);
        reset = 1'b1;

        // Single byte: request two edges after the push, busy drops right after the done pulse.
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t1_tx_en_low", 32'(tx_en), 32'd0);
        chk("t1_tx_byte", 32'(tx_byte), 32'h55);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_count", 32'(count), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t1_tx_en_one_cycle", 32'(tx_en), 32'd1);
        idle(3);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t1_busy_clear", 32'(busy), 32'd0);
        cycle(1'b0, 8'h00, 1'b1);

        // Four back-to-back bytes with a fixed-delay transmitter; launches in order and on the minimum gap.
        launch_log.delete();
        last_done_edge = -1;
        gap_chk = 1'b1;
        tx_delay = 5;
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
        idle(40);
        gap_chk = 1'b0;
        chk("t2_launches", 32'(launch_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < launch_log.size(); i++)
            chk("t2_order", 32'(launch_log[i]), 32'(i + 1));

        // Stalled transmitter: fill to 16 and drop the overflow byte.
        tx_delay = -1;
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        chk("t3_count_peak", 32'(count), 32'd16);
        chk("t3_full", 32'(full), 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
        chk("t3_ovf_set", 32'(ovf), 32'd1);
        ovf_clr_d = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        chk("t3_ovf_clr", 32'(ovf), 32'd0);
        cycle(1'b1, 8'hee, 1'b0);
        chk("t3_ovf_set_wins", 32'(ovf), 32'd1);
        ovf_clr_d = 1'b0;
`endif
        tx_delay = 3;
        cycle(1'b0, 8'h00, 1'b1);
        idle(120);
        chk("t3_drained", 32'(count), 32'd0);

        // Push and launch-pop on the same edge with three entries queued.
        tx_delay = -1;
        cycle(1'b1, 8'ha1, 1'b0);
        cycle(1'b1, 8'ha2, 1'b0);
        cycle(1'b1, 8'ha3, 1'b0);
        cycle(1'b1, 8'ha4, 1'b0);
        idle(1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t4_pre_count", 32'(count), 32'd3);
        tx_delay = 2;
        cycle(1'b1, 8'ha5, 1'b0);
        chk("t4_simul_count", 32'(count), 32'd3);
        chk("t4_simul_launch", 32'(tx_en), 32'd0);

        // Forty random bytes with random gaps, wrapping the pointers.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(200);
        chk("t4_wrap_drained", 32'(count), 32'd0);

        // Asynchronous reset while waiting with five entries queued.
        tx_delay = -1;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t5_queued", 32'(count), 32'd5);
        chk("t5_waiting", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        outstanding = 1'b0;
        last_byte = 8'h00;
        cs_exp = 1'b0;
        ovf_m = 1'b0;
        cd = -1;
        check_all();
        @(negedge sourceClk);
        reset = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        chk("t5_ignored_complete", 32'(busy), 32'd0);
        idle(4);
        chk("t5_no_launch", 32'(tx_en), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
